serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Controller that sequences a single external 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Accepts operands through a valid/ready handshake.
- Each cycle it drives one bit pair plus the running carry into the cell, then captures that cycle's sum and carry.
- Returns the WIDTH-bit sum and the carry-out through a second valid/ready handshake.
- Sits between the operand source and the full_adder cell, which it owns exclusively.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in for bit 0
- fa_a  output  1  bit of A presented to the full-adder cell
- fa_b  output  1  bit of B presented to the full-adder cell
- fa_cin  output  1  running carry presented to the cell
- fa_sum  input  1  cell sum (combinational from fa_a/fa_b/fa_cin)
- fa_cout  input  1  cell carry-out
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result sum bits
- out_cout  output  1  final carry-out
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset is synchronous and active-high. Any cycle with rst=1 forces at the next edge:
  - state=IDLE
  - counter, carry, operand and sum registers = 0
  - out_valid=0, out_cout=0, out_sum=0, busy=0
- Reset takes priority over every other event, including mid-RUN and mid-DONE. An in-flight operation is discarded and no result is produced.
- Registers: a_reg, b_reg, sum_reg [WIDTH]; carry_reg [1]; bit_cnt [max(1,clog2(WIDTH))]; state (IDLE/RUN/DONE).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge: latch in_a→a_reg, in_b→b_reg, in_cin→carry_reg; clear sum_reg and bit_cnt; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and operands are not sampled.
  - Combinationally: fa_a=a_reg[bit_cnt], fa_b=b_reg[bit_cnt], fa_cin=carry_reg.
  - At each edge: sum_reg[bit_cnt]←fa_sum; carry_reg←fa_cout.
  - If bit_cnt==WIDTH-1, go to DONE; otherwise bit_cnt←bit_cnt+1.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_cout=carry_reg; values held stable while out_ready=0, with no timeout.
  - On out_ready=1 at an edge: go to IDLE. out_sum/out_cout keep their last values but are valid only with out_valid.
- Outside RUN: fa_a=fa_b=fa_cin=0, and fa_sum/fa_cout are ignored.
- Latency:
  - Operands accepted at edge T; out_valid rises after edge T+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH bit cycles, handshake, return to IDLE.
- No operand is accepted in the same cycle a result is consumed; in_ready is high only in IDLE.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, computed modulo 2^(WIDTH+1). No overflow flag; overflow appears only as out_cout.
- WIDTH=1: exactly one RUN cycle; bit_cnt stays 0.
- busy = (state != IDLE).

Test Plan:
1. WIDTH=4, a=5, b=3, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=8, cout=0; fa_a sequence observed 1,0,1,0.
2. WIDTH=4, a=15, b=1, cin=0 → sum=0, cout=1. Then a=7, b=8, cin=1 → sum=0, cout=1. Exhaustive 512-vector sweep of a, b, cin matches a reference model.
3. Backpressure: out_ready=0 for 6 cycles after out_valid → out_valid, out_sum, out_cout held constant; in_ready stays 0; accept occurs only after out_ready=1 plus one cycle in IDLE.
4. in_valid held high with changing in_a during RUN → result reflects only the operands latched at accept; no second accept until back in IDLE.
5. rst=1 asserted at the 2nd RUN cycle → next cycle state=IDLE, in_ready=1, out_valid=0, fa_*=0; a subsequent 9+6 gives sum=15, cout=0.
6. WIDTH=1: a=1, b=1, cin=1 → out_valid one cycle after accept; sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: drives an external 1-bit full-adder cell for WIDTH
// cycles, LSB first, to add two WIDTH-bit operands plus a carry-in.
// Operands arrive on a valid/ready handshake; the result leaves on another.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  // A 1-bit counter is kept even for WIDTH=1 so the index is never zero-width.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_bit_cnt == LAST_BIT);

  // Next-state decode: IDLE -> RUN on accept, RUN -> DONE after the top bit,
  // DONE -> IDLE when the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_RUN;
        else          w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake/status flags are registered from the next
  // state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Operand latch on accept, then one sum bit and the carry per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= {WIDTH{1'b0}};
      r_b       <= {WIDTH{1'b0}};
      r_sum     <= {WIDTH{1'b0}};
      r_carry   <= 1'b0;
      r_bit_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_a       <= in_a;
      r_b       <= in_b;
      r_sum     <= {WIDTH{1'b0}};
      r_carry   <= in_cin;
      r_bit_cnt <= {CW{1'b0}};
    end else if (w_run) begin
      r_sum[r_bit_cnt] <= fa_sum;
      r_carry          <= fa_cout;
      if (!w_last) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  // Cell inputs: current bit pair and running carry while running, else 0.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (w_run) begin
      fa_a   = r_a[r_bit_cnt];
      fa_b   = r_b[r_bit_cnt];
      fa_cin = r_carry;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;

endmodule
